// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand sequencer.
// Contents:
//   state_t  - sequencer FSM states (IDLE, RUN, FLUSH)
//   idx_w()  - index width for a dimension of n elements, never below 1 bit
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_operand_sequencer_if.sv
// Operand beat channel of the matrix operand sequencer.
// Signals:
//   Aik, Bkj               - operand pair of the current beat
//   idx_i, idx_j, idx_k    - indices of that pair
//   first_k, last_k        - pair is k==0 / k==KDIM-1
//   out_valid / out_ready  - valid/ready handshake for the beat
// Modports: master (sequencer side), slave (consumer side).
interface matrix_operand_sequencer_if
  import matrix_pkg::*;
#(
  parameter int AROWS     = 4,
  parameter int KDIM      = 4,
  parameter int BCOLUMNS  = 4,
  parameter int WIDTH_BIT = 8
);

  logic [WIDTH_BIT-1:0]       Aik;
  logic [WIDTH_BIT-1:0]       Bkj;
  logic [idx_w(AROWS)-1:0]    idx_i;
  logic [idx_w(BCOLUMNS)-1:0] idx_j;
  logic [idx_w(KDIM)-1:0]     idx_k;
  logic                       first_k;
  logic                       last_k;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output Aik, Bkj, idx_i, idx_j, idx_k, first_k, last_k, out_valid,
    input  out_ready
  );

  modport slave (
    input  Aik, Bkj, idx_i, idx_j, idx_k, first_k, last_k, out_valid,
    output out_ready
  );

endinterface

// File: rtl/matrix_index_counter.sv
// Nested i/j/k position counter (k innermost, then j, then i).
// Ports:
//   clock, reset    - rising-edge clock, asynchronous active-high reset
//   clear           - restart at (0,0,0); the outputs show (0,0,0) this cycle
//   enable          - consume the position shown and advance to the next one
//   i, j, k         - position shown this cycle (clear forces it to zero)
//   k_wrap          - k is at KDIM-1
//   last            - position is (AROWS-1, BCOLUMNS-1, KDIM-1)
// clear and enable together consume (0,0,0) immediately, so a sweep can load
// its first element on the very edge that starts it.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int AROWS    = 4,
  parameter int BCOLUMNS = 4,
  parameter int KDIM     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  output logic [idx_w(AROWS)-1:0]    i,
  output logic [idx_w(BCOLUMNS)-1:0] j,
  output logic [idx_w(KDIM)-1:0]     k,
  output logic                       k_wrap,
  output logic                       last
);

  localparam int IW = idx_w(AROWS);
  localparam int JW = idx_w(BCOLUMNS);
  localparam int KW = idx_w(KDIM);
  localparam logic [IW-1:0] I_MAX = IW'(AROWS - 1);
  localparam logic [JW-1:0] J_MAX = JW'(BCOLUMNS - 1);
  localparam logic [KW-1:0] K_MAX = KW'(KDIM - 1);

  logic [IW-1:0] i_q, i_n;
  logic [JW-1:0] j_q, j_n;
  logic [KW-1:0] k_q, k_n;
  logic          j_wrap;

  // NOTE: every signal written here gets a value before any condition, so no
  // path through the block can leave a latch behind.
  always_comb begin
    i      = clear ? '0 : i_q;
    j      = clear ? '0 : j_q;
    k      = clear ? '0 : k_q;
    k_wrap = (k == K_MAX);
    j_wrap = (j == J_MAX);
    last   = k_wrap && j_wrap && (i == I_MAX);
    i_n    = i;
    j_n    = j;
    k_n    = k;
    if (enable) begin
      if (k_wrap) begin
        k_n = '0;
        if (j_wrap) begin
          j_n = '0;
          i_n = (i == I_MAX) ? '0 : i + 1'b1;
        end else begin
          j_n = j + 1'b1;
        end
      end else begin
        k_n = k + 1'b1;
      end
    end
  end

  // NOTE: registers use <= so all of them sample pre-edge values together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_n;
      j_q <= j_n;
      k_q <= k_n;
    end
  end

endmodule

// File: rtl/matrix_operand_sequencer.sv
// Matrix operand sequencer: streams every (A[i][k], B[k][j]) pair of a
// matrix product, k innermost, over a valid/ready beat channel.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   start          - one-cycle request to begin a sweep (honoured in IDLE only)
//   abort          - synchronous cancel of the running sweep, no done pulse
//   b_transposed   - B layout, latched at start
//   MatrixA        - element (i,k) at flat index i*KDIM + k
//   MatrixB        - element (k,j) at k*BCOLUMNS + j, or at j*KDIM + k when
//                    b_transposed (B stored as BCOLUMNS x KDIM, row-major)
//   busy, done     - sweep in progress; one-cycle completion pulse
//   beat           - operand beat channel (master side)
module matrix_operand_sequencer
  import matrix_pkg::*;
#(
  parameter int AROWS     = 4,
  parameter int KDIM      = 4,
  parameter int BCOLUMNS  = 4,
  parameter int WIDTH_BIT = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 b_transposed,
  input  logic [AROWS*KDIM-1:0][WIDTH_BIT-1:0] MatrixA,
  input  logic [KDIM*BCOLUMNS-1:0][WIDTH_BIT-1:0] MatrixB,
  output logic                                 busy,
  output logic                                 done,
  matrix_operand_sequencer_if.master           beat
);

  localparam int IW = idx_w(AROWS);
  localparam int JW = idx_w(BCOLUMNS);
  localparam int KW = idx_w(KDIM);
  localparam int AW = idx_w(AROWS * KDIM);
  localparam int BW = idx_w(KDIM * BCOLUMNS);

  state_t        state;
  logic          mode;
  logic [IW-1:0] ci;
  logic [JW-1:0] cj;
  logic [KW-1:0] ck;
  logic          k_wrap;
  logic          last;
  logic          accept;
  logic          load;
  logic          transfer;
  logic          cancel;
  logic          finish;
  logic          sel_mode;
  logic [AW-1:0] a_sel;
  logic [BW-1:0] b_sel;

  // The cycle that shows done is already IDLE; a start there is still
  // treated as belonging to the finished sweep and dropped.
  assign accept   = (state == IDLE) && start && !done;
  assign transfer = beat.out_valid && beat.out_ready;
  assign load     = accept ||
                    ((state == RUN) && !abort && (!beat.out_valid || beat.out_ready));
  assign cancel   = abort && (state != IDLE);
  assign finish   = (state == FLUSH) && transfer && !abort;

  // The first pair is fetched on the accepting edge, before mode is latched.
  assign sel_mode = accept ? b_transposed : mode;
  assign a_sel    = AW'(int'(ci) * KDIM + int'(ck));
  assign b_sel    = sel_mode ? BW'(int'(cj) * KDIM + int'(ck))
                             : BW'(int'(ck) * BCOLUMNS + int'(cj));

  matrix_index_counter #(
    .AROWS    (AROWS),
    .BCOLUMNS (BCOLUMNS),
    .KDIM     (KDIM)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (load),
    .i      (ci),
    .j      (cj),
    .k      (ck),
    .k_wrap (k_wrap),
    .last   (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mode  <= b_transposed;
            busy  <= 1'b1;
            state <= last ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (load && last) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (transfer) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat output register: everything reads zero whenever out_valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat.out_valid <= 1'b0;
      beat.Aik       <= '0;
      beat.Bkj       <= '0;
      beat.idx_i     <= '0;
      beat.idx_j     <= '0;
      beat.idx_k     <= '0;
      beat.first_k   <= 1'b0;
      beat.last_k    <= 1'b0;
    end else if (load) begin
      beat.out_valid <= 1'b1;
      beat.Aik       <= MatrixA[a_sel];
      beat.Bkj       <= MatrixB[b_sel];
      beat.idx_i     <= ci;
      beat.idx_j     <= cj;
      beat.idx_k     <= ck;
      beat.first_k   <= (ck == '0);
      beat.last_k    <= k_wrap;
    end else if (cancel || finish) begin
      beat.out_valid <= 1'b0;
      beat.Aik       <= '0;
      beat.Bkj       <= '0;
      beat.idx_i     <= '0;
      beat.idx_j     <= '0;
      beat.idx_k     <= '0;
      beat.first_k   <= 1'b0;
      beat.last_k    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Bench for matrix_operand_sequencer: a 2x3 * 3x2 instance driven by directed
// and random sweeps against a nested-loop reference, plus a 1x1x1 instance.
module tb_matrix_operand_sequencer;
  import matrix_pkg::*;

  localparam int AR = 2;
  localparam int KD = 3;
  localparam int BC = 2;
  localparam int W  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic b_transposed = 1'b0;
  logic [AR*KD-1:0][W-1:0] mat_a = '0;
  logic [KD*BC-1:0][W-1:0] mat_b = '0;
  logic busy, done;

  logic start1 = 1'b0;
  logic [0:0][W-1:0] a1 = '0;
  logic [0:0][W-1:0] b1 = '0;
  logic busy1, done1;

  matrix_operand_sequencer_if #(.AROWS(AR), .KDIM(KD), .BCOLUMNS(BC), .WIDTH_BIT(W)) bus ();
  matrix_operand_sequencer_if #(.AROWS(1), .KDIM(1), .BCOLUMNS(1), .WIDTH_BIT(W)) bus1 ();

  matrix_operand_sequencer #(.AROWS(AR), .KDIM(KD), .BCOLUMNS(BC), .WIDTH_BIT(W)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .b_transposed (b_transposed),
    .MatrixA      (mat_a),
    .MatrixB      (mat_b),
    .busy         (busy),
    .done         (done),
    .beat         (bus)
  );

  matrix_operand_sequencer #(.AROWS(1), .KDIM(1), .BCOLUMNS(1), .WIDTH_BIT(W)) u_dut1 (
    .clock        (clock),
    .reset        (reset),
    .start        (start1),
    .abort        (1'b0),
    .b_transposed (1'b0),
    .MatrixA      (a1),
    .MatrixB      (b1),
    .busy         (busy1),
    .done         (done1),
    .beat         (bus1)
  );

  always #5 clock = ~clock;

  typedef struct {
    int a, b, i, j, k;
    bit first, last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    done_count = 0;
  int    exp_done = 0;
  int    a_m[AR][KD];
  int    b_m[KD][BC];
  bit    ready_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] snap_main();
    return 32'({bus.Aik, bus.Bkj, bus.idx_i, bus.idx_j, bus.idx_k, bus.first_k, bus.last_k});
  endfunction

  // Pack the reference matrices into the port layout for the chosen B mode.
  task automatic load_operands(input bit bt);
    for (int i = 0; i < AR; i++)
      for (int k = 0; k < KD; k++)
        mat_a[i*KD+k] = W'(a_m[i][k]);
    for (int k = 0; k < KD; k++)
      for (int j = 0; j < BC; j++)
        if (bt) mat_b[j*KD+k] = W'(b_m[k][j]);
        else    mat_b[k*BC+j] = W'(b_m[k][j]);
  endtask

  // Reference: the full operand sweep of C = A*B, k innermost.
  task automatic push_sweep();
    for (int i = 0; i < AR; i++)
      for (int j = 0; j < BC; j++)
        for (int k = 0; k < KD; k++)
          exp_q.push_back('{a: a_m[i][k], b: b_m[k][j], i: i, j: j, k: k,
                            first: (k == 0), last: (k == KD - 1)});
  endtask

  task automatic do_start(input bit bt);
    @(posedge clock); #1;
    b_transposed = bt;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    b_transposed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    check("done_seen", 32'(done), 1);
    if (done === 1'b1) exp_done++;
  endtask

  task automatic run_sweep(input bit bt, input bit stall, input bit poke, output int n);
    ready_rand = stall;
    load_operands(bt);
    push_sweep();
    do_start(bt);
    check("first_valid", 32'(bus.out_valid), 1);
    check("busy_after_start", 32'(busy), 1);
    check("first_beat_a", 32'(bus.Aik), a_m[0][0]);
    check("first_beat_b", 32'(bus.Bkj), b_m[0][0]);
    if (poke) begin
      repeat (3) @(posedge clock);
      #1 start = 1'b1;
      repeat (2) @(posedge clock);
      #1 start = 1'b0;
    end
    wait_done(n);
    // start during the done cycle must not launch a sweep
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_at_done_ignored", 32'(busy), 0);
    check("valid_after_done", 32'(bus.out_valid), 0);
  endtask

  task automatic set_example();
    a_m = '{'{1, 2, 3}, '{4, 5, 6}};
    b_m = '{'{7, 8}, '{9, 10}, '{11, 12}};
  endtask

  // Scoreboard monitor: pops on every transfer, checks stalls and idle zeros.
  logic [31:0] held;
  bit          held_ok = 1'b0;
  always @(negedge clock) begin
    logic [31:0] snap;
    beat_t       e;
    snap = snap_main();
    if (bus.out_valid) begin
      if (held_ok) check("stall_hold", snap, held);
      if (bus.out_ready && !abort) begin
        check("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("Aik", 32'(bus.Aik), e.a);
          check("Bkj", 32'(bus.Bkj), e.b);
          check("idx_i", 32'(bus.idx_i), e.i);
          check("idx_j", 32'(bus.idx_j), e.j);
          check("idx_k", 32'(bus.idx_k), e.k);
          check("first_k", 32'(bus.first_k), 32'(e.first));
          check("last_k", 32'(bus.last_k), 32'(e.last));
        end
        held_ok = 1'b0;
      end else begin
        held_ok = !abort;
        held    = snap;
      end
    end else begin
      held_ok = 1'b0;
      check("idle_zero", snap, 0);
    end
    if (done) begin
      done_count++;
      check("done_after_last", exp_q.size(), 0);
      check("busy_low_at_done", 32'(busy), 0);
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus1.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_outputs", snap_main(), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;

    // Worked example, ready always high; done 12 edges after the accepting edge
    set_example();
    run_sweep(1'b0, 1'b0, 1'b0, n);
    check("done_latency", n, 12);

    // Same operands with B stored transposed
    run_sweep(1'b1, 1'b0, 1'b0, n);
    check("done_latency_bt", n, 12);

    // Back-pressure and start pulses while busy
    run_sweep(1'b0, 1'b1, 1'b0, n);
    run_sweep(1'b0, 1'b0, 1'b1, n);

    // Abort while beat 5 is presented
    ready_rand = 1'b0;
    load_operands(1'b0);
    push_sweep();
    do_start(1'b0);
    repeat (4) @(posedge clock);
    #1;
    check("beat5_idx_k", 32'(bus.idx_k), 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    run_sweep(1'b0, 1'b0, 1'b0, n);

    // Reset while beat 7 is presented
    load_operands(1'b0);
    push_sweep();
    do_start(1'b0);
    repeat (6) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_outputs", snap_main(), 0);
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    exp_q.delete();
    #10 reset = 1'b0;
    run_sweep(1'b0, 1'b0, 1'b0, n);

    // Random operands, modes and back-pressure
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < AR; i++)
        for (int k = 0; k < KD; k++)
          a_m[i][k] = $urandom_range(0, 255);
      for (int k = 0; k < KD; k++)
        for (int j = 0; j < BC; j++)
          b_m[k][j] = $urandom_range(0, 255);
      run_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), n);
    end

    // Single-element instance: one beat with both k flags set
    a1[0] = 8'h5a;
    b1[0] = 8'hc3;
    @(posedge clock); #1 start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
    check("s_valid", 32'(bus1.out_valid), 1);
    check("s_aik", 32'(bus1.Aik), 32'h5a);
    check("s_bkj", 32'(bus1.Bkj), 32'hc3);
    check("s_flags", 32'({bus1.first_k, bus1.last_k}), 3);
    check("s_idx", 32'({bus1.idx_i, bus1.idx_j, bus1.idx_k}), 0);
    check("s_busy", 32'(busy1), 1);
    @(posedge clock); #1;
    check("s_done", 32'(done1), 1);
    check("s_valid_drop", 32'(bus1.out_valid), 0);
    check("s_busy_drop", 32'(busy1), 0);
    @(posedge clock); #1;
    check("s_done_pulse", 32'(done1), 0);

    repeat (3) @(posedge clock);
    #1;
    check("done_count", done_count, exp_done);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
